// File: rtl/sub32_4.sv
// Four-stage pipelined 32-bit subtractor: diff = a - b - bin, one byte per stage, registered borrow ripple.
// Latency 4 enabled edges; stop freezes every register; valid tag and signed-overflow flag ride along.
module sub32_4 (
  input  logic        clk,
  input  logic        rst,
  input  logic        stop,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        bin,
  input  logic        in_valid,
  output logic [31:0] diff,
  output logic        bout,
  output logic        ovf,
  output logic        out_valid
);

  // stage 1: byte 0 done, bytes 3:1 of a/b still pending
  logic [7:0]  d1;
  logic        br1;
  logic [23:0] a1, b1;
  logic        v1;
  // stage 2
  logic [15:0] d2;
  logic        br2;
  logic [15:0] a2, b2;
  logic        v2;
  // stage 3
  logic [23:0] d3;
  logic        br3;
  logic [7:0]  a3, b3;
  logic        v3;

  // a - b - borrow == a + ~b + ~borrow; carry-out is the inverse of borrow-out
  logic [8:0] s1, s2, s3, s4;
  assign s1 = {1'b0, a[7:0]}  + {1'b0, ~b[7:0]}  + {8'd0, ~bin};
  assign s2 = {1'b0, a1[7:0]} + {1'b0, ~b1[7:0]} + {8'd0, ~br1};
  assign s3 = {1'b0, a2[7:0]} + {1'b0, ~b2[7:0]} + {8'd0, ~br2};
  assign s4 = {1'b0, a3}      + {1'b0, ~b3}      + {8'd0, ~br3};

  always_ff @(posedge clk) begin
    if (rst) begin
      d1 <= '0; br1 <= 1'b0; a1 <= '0; b1 <= '0; v1 <= 1'b0;
      d2 <= '0; br2 <= 1'b0; a2 <= '0; b2 <= '0; v2 <= 1'b0;
      d3 <= '0; br3 <= 1'b0; a3 <= '0; b3 <= '0; v3 <= 1'b0;
      diff <= '0; bout <= 1'b0; ovf <= 1'b0; out_valid <= 1'b0;
    end else if (!stop) begin
      d1  <= s1[7:0];
      br1 <= ~s1[8];
      a1  <= a[31:8];
      b1  <= b[31:8];
      v1  <= in_valid;

      d2  <= {s2[7:0], d1};
      br2 <= ~s2[8];
      a2  <= a1[23:8];
      b2  <= b1[23:8];
      v2  <= v1;

      d3  <= {s3[7:0], d2};
      br3 <= ~s3[8];
      a3  <= a2[15:8];
      b3  <= b2[15:8];
      v3  <= v2;

      diff      <= {s4[7:0], d3};
      bout      <= ~s4[8];
      // overflow only possible when operand signs differ and the result sign flips away from a
      ovf       <= (a3[7] ^ b3[7]) & (s4[7] ^ a3[7]);
      out_valid <= v3;
    end
  end

endmodule

// File: tb/tb_sub32_4.sv
// Directed and random checks for sub32_4: reset, ripple, overflow, stall, bubbles, mid-flight reset.
module tb_sub32_4;

  logic        clk = 1'b0;
  logic        rst;
  logic        stop;
  logic [31:0] a, b;
  logic        bin;
  logic        in_valid;
  logic [31:0] diff;
  logic        bout, ovf, out_valid;

  int n_chk  = 0;
  int n_pass = 0;

  logic        mv [4];
  logic [33:0] md [4];

  sub32_4 dut (
    .clk(clk), .rst(rst), .stop(stop), .a(a), .b(b), .bin(bin), .in_valid(in_valid),
    .diff(diff), .bout(bout), .ovf(ovf), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // reference: {ovf, bout, diff} from a 33-bit subtraction
  function automatic logic [33:0] ref_sub(input logic [31:0] x, input logic [31:0] y, input logic c);
    logic [32:0] r;
    logic        o;
    r = {1'b0, x} - {1'b0, y} - {32'd0, c};
    o = (x[31] != y[31]) && (r[31] != x[31]);
    return {o, r[32], r[31:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic [31:0] ed,
                         input logic eb, input logic eo);
    chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, ev});
    if (ev) begin
      chk({tag, ".diff"}, diff, ed);
      chk({tag, ".bout"}, {31'd0, bout}, {31'd0, eb});
      chk({tag, ".ovf"},  {31'd0, ovf},  {31'd0, eo});
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, ".diff"}, diff, 32'd0);
    chk({tag, ".bout"}, {31'd0, bout}, 32'd0);
    chk({tag, ".ovf"},  {31'd0, ovf},  32'd0);
  endtask

  // one clock edge; the bench's own latency model advances with it
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        mv[i] = 1'b0;
        md[i] = '0;
      end
    end else if (!stop) begin
      for (int i = 3; i > 0; i--) begin
        mv[i] = mv[i-1];
        md[i] = md[i-1];
      end
      mv[0] = in_valid;
      md[0] = ref_sub(a, b, bin);
    end
    #1;
  endtask

  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic c);
    a = x; b = y; bin = c; in_valid = 1'b1;
    tick();
  endtask

  task automatic idle();
    a = $urandom; b = $urandom; bin = 1'($urandom_range(0, 1)); in_valid = 1'b0;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      mv[i] = 1'b0;
      md[i] = '0;
    end
    rst = 1'b1; stop = 1'b0;
    a = $urandom; b = $urandom; bin = 1'b1; in_valid = 1'b1;
    #1;
    tick();
    a = $urandom; b = $urandom;
    tick();
    chk_zero("reset");

    // basic, full borrow ripple, signed overflow, bin with equal operands
    rst = 1'b0;
    issue(32'd5, 32'd3, 1'b0);
    issue(32'd0, 32'd1, 1'b0);
    issue(32'h8000_0000, 32'd1, 1'b0);
    chk_out("latency", 1'b0, 32'd0, 1'b0, 1'b0);
    issue(32'h1234_5678, 32'h1234_5678, 1'b1);
    chk_out("basic", 1'b1, 32'h0000_0002, 1'b0, 1'b0);
    idle();
    chk_out("ripple", 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    idle();
    chk_out("ovf", 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1);
    idle();
    chk_out("bin_eq", 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    idle();
    chk_out("drain", 1'b0, 32'd0, 1'b0, 1'b0);

    // stall with three operations in flight
    issue(32'h0000_0010, 32'd1, 1'b0);
    issue(32'h0000_0100, 32'd1, 1'b0);
    issue(32'h0001_0000, 32'd1, 1'b0);
    issue(32'h0100_0000, 32'd1, 1'b0);
    chk_out("st_op0", 1'b1, 32'h0000_000F, 1'b0, 1'b0);
    stop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = $urandom; b = $urandom; bin = 1'b1; in_valid = 1'b1;
      tick();
      chk_out("st_frozen", 1'b1, 32'h0000_000F, 1'b0, 1'b0);
    end
    stop = 1'b0;
    issue(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk_out("st_op1", 1'b1, 32'h0000_00FF, 1'b0, 1'b0);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    chk_out("st_op2", 1'b1, 32'h0000_FFFF, 1'b0, 1'b0);
    idle();
    chk_out("st_op3", 1'b1, 32'h00FF_FFFF, 1'b0, 1'b0);
    idle();
    chk_out("st_op4", 1'b1, 32'h8000_0000, 1'b1, 1'b1);
    idle();
    chk_out("st_op5", 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    idle();
    chk_out("st_nodup0", 1'b0, 32'd0, 1'b0, 1'b0);
    idle();
    chk_out("st_nodup1", 1'b0, 32'd0, 1'b0, 1'b0);

    // bubbles
    issue(32'd10, 32'd3, 1'b0);
    idle();
    issue(32'd3, 32'd10, 1'b0);
    idle();
    chk_out("bub0", 1'b1, 32'h0000_0007, 1'b0, 1'b0);
    idle();
    chk_out("bub1", 1'b0, 32'd0, 1'b0, 1'b0);
    idle();
    chk_out("bub2", 1'b1, 32'hFFFF_FFF9, 1'b1, 1'b0);
    idle();
    chk_out("bub3", 1'b0, 32'd0, 1'b0, 1'b0);

    // reset with three operations in flight
    issue(32'd100, 32'd1, 1'b0);
    issue(32'd200, 32'd2, 1'b0);
    issue(32'd300, 32'd3, 1'b0);
    rst = 1'b1; stop = 1'b1; in_valid = 1'b0;
    tick();
    chk_zero("midrst");
    rst = 1'b0; stop = 1'b0;
    for (int i = 0; i < 5; i++) begin
      idle();
      chk_out("midrst_flush", 1'b0, 32'd0, 1'b0, 1'b0);
    end

    // random stream against the reference model
    for (int i = 0; i < 10000; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 15) == 0) ? a : $urandom;
      bin = 1'($urandom_range(0, 1));
      in_valid = ($urandom_range(0, 3) != 0);
      stop = ($urandom_range(0, 4) == 0);
      tick();
      chk_out("rnd", mv[3], md[3][31:0], md[3][32], md[3][33]);
    end
    stop = 1'b0; in_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
